// File: rtl/reset_vector_reader_pkg.sv
// Shared defaults and FSM encodings for the reset-vector readout reader.
// Field widths match the boot-ROM emulator's readout port.
package reset_vector_reader_pkg;

    localparam int ADDR_N_DEF  = 19;
    localparam int CHUNK_N_DEF = 2;
    localparam int IDX_N_DEF   = 5;
    localparam int DIV_DEF     = 4;
    localparam int TIMEOUT_DEF = 1024;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WAIT_S = 3'd1;
    localparam logic [2:0] ST_SETUP  = 3'd2;
    localparam logic [2:0] ST_HOLD   = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    // Counter width for n states, never narrower than one bit.
    function automatic int cw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reset_vector_reader_sync2.sv
// Two-flop synchronizer for the emulator's asynchronous capture flag.
module reset_vector_reader_sync2 (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/reset_vector_reader.sv
// Walks the emulator's chunk index, strobes its readout clock and reassembles
// the captured CPU reset address from the returned chunks.
module reset_vector_reader
    import reset_vector_reader_pkg::*;
#(
    parameter int ADDR_N  = ADDR_N_DEF,
    parameter int CHUNK_N = CHUNK_N_DEF,
    parameter int IDX_N   = IDX_N_DEF,
    parameter int DIV     = DIV_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic               i_clk,
    input  logic               _rst,
    input  logic               i_start,
    input  logic               i_s,
    output logic               o_rclk,
    output logic [IDX_N-1:0]   o_ridx,
    input  logic [CHUNK_N-1:0] i_rdata,
    output logic [ADDR_N-1:0]  o_vaddr,
    output logic               o_valid,
    output logic               o_busy,
    output logic               o_err
);

    localparam int NCHUNK = (ADDR_N + CHUNK_N - 1) / CHUNK_N;
    localparam int SW     = NCHUNK * CHUNK_N;
    localparam int PH_W   = cw(DIV);
    localparam int TO_W   = cw(TIMEOUT);

    logic              s_sync;
    logic [2:0]        state_q, state_d;
    logic [PH_W-1:0]   ph_q, ph_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic [IDX_N-1:0]  idx_q, idx_d;
    logic [SW-1:0]     shadow_q, shadow_d;
    logic              rclk_q, rclk_d;
    logic [IDX_N-1:0]  ridx_q, ridx_d;
    logic [ADDR_N-1:0] vaddr_q, vaddr_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;

    // Any set bit above the address width means the emulator returned garbage.
    function automatic logic pad_any(input logic [SW-1:0] sh);
        logic p;
        p = 1'b0;
        for (int b = ADDR_N; b < SW; b++) p = p | sh[b];
        return p;
    endfunction

    reset_vector_reader_sync2 u_sync (
        .clk_i  (i_clk),
        .rst_ni (_rst),
        .d_i    (i_s),
        .q_o    (s_sync)
    );

    always_comb begin
        state_d  = state_q;
        ph_d     = ph_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        vaddr_d  = vaddr_q;
        valid_d  = valid_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_WAIT_S;
                    valid_d = 1'b0;
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            ST_WAIT_S: begin
                if (s_sync) begin
                    state_d = ST_SETUP;
                    idx_d   = '0;
                    ph_d    = '0;
                end else if (cnt_q == TO_W'(TIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                    valid_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SETUP: begin
                if (ph_q == PH_W'(DIV - 1)) begin
                    ph_d    = '0;
                    state_d = ST_HOLD;
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (ph_q == PH_W'(DIV - 1)) begin
                    ph_d = '0;
                    for (int k = 0; k < NCHUNK; k++) begin
                        if (idx_q == IDX_N'(k)) shadow_d[k*CHUNK_N +: CHUNK_N] = i_rdata;
                    end
                    if (idx_q == IDX_N'(NCHUNK - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_SETUP;
                    end
                end else begin
                    ph_d = ph_q + 1'b1;
                end
            end
            ST_DONE: begin
                vaddr_d = shadow_q[ADDR_N-1:0];
                valid_d = 1'b1;
                err_d   = pad_any(shadow_q);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Readout clock and index are registered from the next state so both
        // move on the same edge; the index only changes with the clock high.
        rclk_d = (state_d != ST_HOLD);
        ridx_d = (state_d == ST_SETUP || state_d == ST_HOLD) ? idx_d : '0;
    end

    always_ff @(posedge i_clk or negedge _rst) begin
        if (!_rst) begin
            state_q  <= ST_IDLE;
            ph_q     <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            rclk_q   <= 1'b1;
            ridx_q   <= '0;
            vaddr_q  <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ph_q     <= ph_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            rclk_q   <= rclk_d;
            ridx_q   <= ridx_d;
            vaddr_q  <= vaddr_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign o_rclk  = rclk_q;
    assign o_ridx  = ridx_q;
    assign o_vaddr = vaddr_q;
    assign o_valid = valid_q;
    assign o_busy  = (state_q != ST_IDLE);
    assign o_err   = err_q;

endmodule
